// File: rtl/mapper_bus_mux_pkg.sv
// Shared types and helpers for the cartridge-mapper bus mux.
package mapper_pkg;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } mapmux_state_t;

  localparam logic [5:0] MAPMUX_TURBO_BLOCK_DEF = 6'b001010;

  // Channel index for a map_active vector: bit k-1 -> channel k, 0 when idle.
  function automatic int onehot_idx(input logic [31:0] v);
    int r = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) r = i + 1;
    return r;
  endfunction

  function automatic logic popcnt_gt1(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) c += {31'd0, v[i]};
    return c > 1;
  endfunction

endpackage

// File: rtl/mapper_bus_mux_if.sv
// Mapper-side channel bundle plus the muxed CPU/memory-controller side.
interface mapper_bus_mux_if #(
  parameter int NCH    = 6,
  parameter int ROM_AW = 24,
  parameter int BS_AW  = 20
);
  logic [NCH-2:0]        map_active;
  logic [8*NCH-1:0]      ch_do;
  logic [NCH-1:0]        ch_irq_n;
  logic [ROM_AW*NCH-1:0] ch_rom_addr;
  logic [NCH-1:0]        ch_rom_ce_n, ch_rom_oe_n, ch_rom_word;
  logic [BS_AW*NCH-1:0]  ch_bsram_addr;
  logic [8*NCH-1:0]      ch_bsram_d;
  logic [NCH-1:0]        ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n, ch_bsram_rd_n;

  logic [7:0]            cpu_di;
  logic                  irq_n;
  logic [ROM_AW-1:0]     rom_addr;
  logic                  rom_ce_n, rom_oe_n, rom_word;
  logic [BS_AW-1:0]      bsram_addr;
  logic [7:0]            bsram_d;
  logic                  bsram_ce_n, bsram_oe_n, bsram_we_n, bsram_rd_n;
  logic [$clog2(NCH)-1:0] sel;
  logic                  locked, conflict, turbo_allow;

  modport slave (
    input  map_active, ch_do, ch_irq_n, ch_rom_addr, ch_rom_ce_n, ch_rom_oe_n, ch_rom_word,
           ch_bsram_addr, ch_bsram_d, ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n, ch_bsram_rd_n,
    output cpu_di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word, bsram_addr, bsram_d,
           bsram_ce_n, bsram_oe_n, bsram_we_n, bsram_rd_n, sel, locked, conflict, turbo_allow
  );

  modport master (
    output map_active, ch_do, ch_irq_n, ch_rom_addr, ch_rom_ce_n, ch_rom_oe_n, ch_rom_word,
           ch_bsram_addr, ch_bsram_d, ch_bsram_ce_n, ch_bsram_oe_n, ch_bsram_we_n, ch_bsram_rd_n,
    input  cpu_di, irq_n, rom_addr, rom_ce_n, rom_oe_n, rom_word, bsram_addr, bsram_d,
           bsram_ce_n, bsram_oe_n, bsram_we_n, bsram_rd_n, sel, locked, conflict, turbo_allow
  );
endinterface

// File: rtl/mapper_bus_mux_settle.sv
// map_active debouncer / selection lock: settles, locks onto one channel, and
// latches a sticky fault when two mappers claim the bus at once.
module mapmux_settle
  import mapper_pkg::*;
#(
  parameter int NCH           = 6,
  parameter int STABLE_CYCLES = 4,
  parameter int SW            = $clog2(NCH)
) (
  input  logic           mclk,
  input  logic           rst_n,
  input  logic [NCH-2:0] map_active_i,
  output logic [SW-1:0]  sel_o,
  output logic           locked_o,
  output logic           conflict_o
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STAB_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_CYCLES - 1);

  mapmux_state_t  state_q, state_d;
  logic [NCH-2:0] ma_q;
  logic [CW-1:0]  stab_q, stab_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic           conflict_q, conflict_d;
  logic           changed;

  assign changed = (map_active_i != ma_q);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SETTLE;
      ma_q       <= '0;
      stab_q     <= '0;
      sel_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ma_q       <= map_active_i;
      stab_q     <= stab_d;
      sel_q      <= sel_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    sel_d      = sel_q;
    conflict_d = conflict_q;
    // Multi-claim beats every other transition and is only cleared by reset.
    if (popcnt_gt1(32'(map_active_i))) begin
      state_d    = FAULT;
      sel_d      = '0;
      conflict_d = 1'b1;
    end else begin
      case (state_q)
        SETTLE: begin
          if (changed) stab_d = '0;
          else begin
            if (stab_q != STAB_MAX) stab_d = stab_q + CW'(1);
            if (stab_q >= STAB_LAST) begin
              state_d = LOCKED;
              sel_d   = SW'(onehot_idx(32'(map_active_i)));
            end
          end
        end
        LOCKED: begin
          if (changed) begin
            state_d = SETTLE;
            stab_d  = '0;
            sel_d   = '0;
          end
        end
        FAULT:   ;
        default: state_d = SETTLE;
      endcase
    end
  end

  assign sel_o      = sel_q;
  assign locked_o   = (state_q == LOCKED);
  assign conflict_o = conflict_q;
endmodule

// File: rtl/mapper_bus_mux.sv
// Stateful cartridge-mapper bus mux; channel 0 is the default mapper.
// Define MAPMUX_REG_OUT_EN to register the ROM/BSRAM outputs (cpu_di/irq_n stay combinational).
module mapper_bus_mux
  import mapper_pkg::*;
#(
  parameter int NCH           = 6,
  parameter int ROM_AW        = 24,
  parameter int BS_AW         = 20,
  parameter int STABLE_CYCLES = 4,
  parameter logic [NCH-1:0] TURBO_BLOCK = NCH'(MAPMUX_TURBO_BLOCK_DEF)
) (
  input  logic mclk,
  input  logic rst_n,
  mapper_bus_mux_if.slave bus
);
  localparam int SW = $clog2(NCH);

  logic [SW-1:0]     sel;
  logic              locked, conflict;
  logic [ROM_AW-1:0] rom_addr_d;
  logic [BS_AW-1:0]  bsram_addr_d;
  logic [7:0]        bsram_d_d;
  // {rom_ce_n, rom_oe_n, rom_word, bsram_ce_n, bsram_oe_n, bsram_we_n, bsram_rd_n}
  logic [6:0]        strb_d;

  mapmux_settle #(.NCH(NCH), .STABLE_CYCLES(STABLE_CYCLES), .SW(SW)) u_settle (
    .mclk        (mclk),
    .rst_n       (rst_n),
    .map_active_i(bus.map_active),
    .sel_o       (sel),
    .locked_o    (locked),
    .conflict_o  (conflict)
  );

  // sel is already 0 outside LOCKED, so one index serves every state.
  assign bus.cpu_di   = bus.ch_do[8*sel +: 8];
  assign bus.irq_n    = bus.ch_irq_n[sel];
  assign rom_addr_d   = bus.ch_rom_addr[ROM_AW*sel +: ROM_AW];
  assign bsram_addr_d = bus.ch_bsram_addr[BS_AW*sel +: BS_AW];
  assign bsram_d_d    = bus.ch_bsram_d[8*sel +: 8];
  assign strb_d = {bus.ch_rom_ce_n[sel], bus.ch_rom_oe_n[sel], bus.ch_rom_word[sel],
                   bus.ch_bsram_ce_n[sel], bus.ch_bsram_oe_n[sel],
                   bus.ch_bsram_we_n[sel], bus.ch_bsram_rd_n[sel]};

`ifdef MAPMUX_REG_OUT_EN
  logic [ROM_AW-1:0] rom_addr_q;
  logic [BS_AW-1:0]  bsram_addr_q;
  logic [7:0]        bsram_d_q;
  logic [6:0]        strb_q;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q   <= '0;
      bsram_addr_q <= '0;
      bsram_d_q    <= '0;
      strb_q       <= 7'b1101111;
    end else begin
      rom_addr_q   <= rom_addr_d;
      bsram_addr_q <= bsram_addr_d;
      bsram_d_q    <= bsram_d_d;
      strb_q       <= strb_d;
    end
  end

  assign bus.rom_addr   = rom_addr_q;
  assign bus.bsram_addr = bsram_addr_q;
  assign bus.bsram_d    = bsram_d_q;
  assign {bus.rom_ce_n, bus.rom_oe_n, bus.rom_word, bus.bsram_ce_n,
          bus.bsram_oe_n, bus.bsram_we_n, bus.bsram_rd_n} = strb_q;
`else
  assign bus.rom_addr   = rom_addr_d;
  assign bus.bsram_addr = bsram_addr_d;
  assign bus.bsram_d    = bsram_d_d;
  assign {bus.rom_ce_n, bus.rom_oe_n, bus.rom_word, bus.bsram_ce_n,
          bus.bsram_oe_n, bus.bsram_we_n, bus.bsram_rd_n} = strb_d;
`endif

  assign bus.sel         = sel;
  assign bus.locked      = locked;
  assign bus.conflict    = conflict;
  assign bus.turbo_allow = locked & ((sel == '0) | ~TURBO_BLOCK[sel]);
endmodule

// File: tb/tb_mapper_bus_mux.sv
// Directed bench for mapper_bus_mux: per-cycle model compare plus hand-computed pins.
module tb_mapper_bus_mux;
  localparam int NCH = 6;
  localparam int ROM_AW = 24;
  localparam int BS_AW = 20;
  localparam int SC = 4;

  logic mclk, rst_n, go;
  int   cyc_d;
  logic [23:0] rom_bump;
  int   n_tests, n_fail;
  logic [5:0] tbk;

  mapper_bus_mux_if #(.NCH(NCH), .ROM_AW(ROM_AW), .BS_AW(BS_AW)) bus ();

  mapper_bus_mux #(.NCH(NCH), .ROM_AW(ROM_AW), .BS_AW(BS_AW), .STABLE_CYCLES(SC),
                   .TURBO_BLOCK(6'b001010)) dut (
    .mclk(mclk), .rst_n(rst_n), .bus(bus));

  initial begin mclk = 1'b0; forever #5 mclk = ~mclk; end
  initial begin cyc_d = 0; forever begin @(posedge mclk); #1 cyc_d = cyc_d + 1; end end

  // ---- per-channel stimulus patterns
  function automatic logic [7:0]  f_do(int k, int c);  return 8'(k*16 + c%16); endfunction
  function automatic logic        f_irq(int k, int c); return ((c+k)%3) != 0; endfunction
  function automatic logic [6:0]  f_st(int k, int c);  return 7'((c+k)*37); endfunction
  function automatic logic [19:0] f_ba(int k, int c);  return 20'(k*4096 + c); endfunction
  function automatic logic [7:0]  f_bd(int k, int c);  return 8'(c) ^ 8'(k*17); endfunction
  function automatic logic [23:0] f_rom(int k, logic [23:0] b);
    return {4'hA, 4'(k), 16'h1234} ^ ((k == 3) ? b : 24'h0);
  endfunction

  function automatic logic [8*NCH-1:0] pk_do(int c);
    logic [8*NCH-1:0] r; for (int k = 0; k < NCH; k++) r[8*k +: 8] = f_do(k, c); return r;
  endfunction
  function automatic logic [8*NCH-1:0] pk_bd(int c);
    logic [8*NCH-1:0] r; for (int k = 0; k < NCH; k++) r[8*k +: 8] = f_bd(k, c); return r;
  endfunction
  function automatic logic [NCH-1:0] pk_irq(int c);
    logic [NCH-1:0] r; for (int k = 0; k < NCH; k++) r[k] = f_irq(k, c); return r;
  endfunction
  function automatic logic [NCH-1:0] pk_st(int c, int j);
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) begin logic [6:0] s; s = f_st(k, c); r[k] = s[j]; end
    return r;
  endfunction
  function automatic logic [BS_AW*NCH-1:0] pk_ba(int c);
    logic [BS_AW*NCH-1:0] r; for (int k = 0; k < NCH; k++) r[BS_AW*k +: BS_AW] = f_ba(k, c); return r;
  endfunction
  function automatic logic [ROM_AW*NCH-1:0] pk_rom(logic [23:0] b);
    logic [ROM_AW*NCH-1:0] r; for (int k = 0; k < NCH; k++) r[ROM_AW*k +: ROM_AW] = f_rom(k, b); return r;
  endfunction

  assign bus.ch_do         = pk_do(cyc_d);
  assign bus.ch_irq_n      = pk_irq(cyc_d);
  assign bus.ch_rom_addr   = pk_rom(rom_bump);
  assign bus.ch_rom_ce_n   = pk_st(cyc_d, 6);
  assign bus.ch_rom_oe_n   = pk_st(cyc_d, 5);
  assign bus.ch_rom_word   = pk_st(cyc_d, 4);
  assign bus.ch_bsram_ce_n = pk_st(cyc_d, 3);
  assign bus.ch_bsram_oe_n = pk_st(cyc_d, 2);
  assign bus.ch_bsram_we_n = pk_st(cyc_d, 1);
  assign bus.ch_bsram_rd_n = pk_st(cyc_d, 0);
  assign bus.ch_bsram_addr = pk_ba(cyc_d);
  assign bus.ch_bsram_d    = pk_bd(cyc_d);

  // ---- model: count consecutive unchanged samples; locked once SC of them are seen
  logic [NCH-2:0] m_prev;
  int             m_run;
  logic           m_fault;
`ifdef MAPMUX_REG_OUT_EN
  logic [23:0] er_rom; logic [19:0] er_ba; logic [7:0] er_bd; logic [6:0] er_st;
`endif

  function automatic logic exp_locked(); return !m_fault && m_run >= SC; endfunction
  function automatic int exp_sel();
    if (!exp_locked()) return 0;
    for (int k = 0; k < NCH-1; k++) if (m_prev[k]) return k + 1;
    return 0;
  endfunction

  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev <= '0; m_run <= 0; m_fault <= 1'b0;
`ifdef MAPMUX_REG_OUT_EN
      er_rom <= '0; er_ba <= '0; er_bd <= '0; er_st <= 7'b1101111;
`endif
    end else begin
      if ($countones(bus.map_active) > 1) m_fault <= 1'b1;
      if (bus.map_active != m_prev) m_run <= 0;
      else if (m_run < SC) m_run <= m_run + 1;
      m_prev <= bus.map_active;
`ifdef MAPMUX_REG_OUT_EN
      er_rom <= f_rom(exp_sel(), rom_bump); er_ba <= f_ba(exp_sel(), cyc_d);
      er_bd  <= f_bd(exp_sel(), cyc_d);     er_st <= f_st(exp_sel(), cyc_d);
`endif
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge mclk) begin
    int s; logic [23:0] x_rom; logic [19:0] x_ba; logic [7:0] x_bd; logic [6:0] x_st;
    if (go) begin
      s = exp_sel();
`ifdef MAPMUX_REG_OUT_EN
      x_rom = er_rom; x_ba = er_ba; x_bd = er_bd; x_st = er_st;
`else
      x_rom = f_rom(s, rom_bump); x_ba = f_ba(s, cyc_d); x_bd = f_bd(s, cyc_d); x_st = f_st(s, cyc_d);
`endif
      chk("cpu_di", 32'(bus.cpu_di), 32'(f_do(s, cyc_d)));
      chk("irq_n", 32'(bus.irq_n), 32'(f_irq(s, cyc_d)));
      chk("rom_addr", 32'(bus.rom_addr), 32'(x_rom));
      chk("bsram_addr", 32'(bus.bsram_addr), 32'(x_ba));
      chk("bsram_d", 32'(bus.bsram_d), 32'(x_bd));
      chk("strobes", 32'({bus.rom_ce_n, bus.rom_oe_n, bus.rom_word, bus.bsram_ce_n,
                          bus.bsram_oe_n, bus.bsram_we_n, bus.bsram_rd_n}), 32'(x_st));
      chk("sel", 32'(bus.sel), 32'(s));
      chk("locked", 32'(bus.locked), 32'(exp_locked()));
      chk("conflict", 32'(bus.conflict), 32'(m_fault));
      chk("turbo_allow", 32'(bus.turbo_allow), 32'(exp_locked() && (s == 0 || !tbk[s])));
    end
  end

  task automatic tick(int n); repeat (n) @(posedge mclk); #2; endtask

  task automatic pin_lock(string nm, logic l, logic [2:0] s, logic t);
    chk({nm, ".locked"}, 32'(bus.locked), 32'(l));
    chk({nm, ".sel"}, 32'(bus.sel), 32'(s));
    chk({nm, ".turbo"}, 32'(bus.turbo_allow), 32'(t));
  endtask

  initial begin
    n_tests = 0; n_fail = 0; go = 1'b0; tbk = 6'b001010;
    rst_n = 1'b0; bus.map_active = '0; rom_bump = '0;
    repeat (3) @(posedge mclk); #2;
    go = 1'b1;
    pin_lock("reset", 1'b0, 3'd0, 1'b0);
    chk("reset.conflict", 32'(bus.conflict), 32'd0);

    // lock onto channel 3: ma_q load + 4 stable samples
    bus.map_active = 5'b00100; rst_n = 1'b1;
    tick(4); pin_lock("ch3_pre", 1'b0, 3'd0, 1'b0);
    tick(1); pin_lock("ch3_lock", 1'b1, 3'd3, 1'b0);
    tick(1); chk("ch3_rom", 32'(bus.rom_addr), 32'h00A31234);

    rom_bump = 24'h00FF00; #1;
    chk("bump_cpu_di", 32'(bus.cpu_di), 32'(8'(48 + cyc_d % 16)));
`ifdef MAPMUX_REG_OUT_EN
    chk("bump_rom_hold", 32'(bus.rom_addr), 32'h00A31234);
    tick(1);
`endif
    chk("bump_rom", 32'(bus.rom_addr), 32'h00A3ED34);
    tick(1); rom_bump = '0;

    // switch to channel 2: drop next edge, relock after 4 stable edges
    bus.map_active = 5'b00010;
    tick(1); pin_lock("ch2_drop", 1'b0, 3'd0, 1'b0);
    tick(3); pin_lock("ch2_pre", 1'b0, 3'd0, 1'b0);
    tick(1); pin_lock("ch2_lock", 1'b1, 3'd2, 1'b1);

    bus.map_active = 5'b00001;
    tick(5); pin_lock("ch1_lock", 1'b1, 3'd1, 1'b0);

    // idle map_active: ma_q already matches, so 4 edges suffice
    rst_n = 1'b0; bus.map_active = '0; tick(1); rst_n = 1'b1;
    tick(3); pin_lock("ch0_pre", 1'b0, 3'd0, 1'b0);
    tick(1); pin_lock("ch0_lock", 1'b1, 3'd0, 1'b1);

    bus.map_active = 5'b00110;
    tick(1); chk("conf_set", 32'(bus.conflict), 32'd1); pin_lock("conf", 1'b0, 3'd0, 1'b0);
    bus.map_active = 5'b00100;
    tick(8); chk("conf_sticky", 32'(bus.conflict), 32'd1); pin_lock("conf_hold", 1'b0, 3'd0, 1'b0);
    rst_n = 1'b0; #1;
    chk("conf_clear", 32'(bus.conflict), 32'd0);
    tick(1); rst_n = 1'b1;

    // reset three edges into SETTLE must restart the full lock count
    tick(3); rst_n = 1'b0; #1;
    chk("midrst_locked", 32'(bus.locked), 32'd0);
`ifdef MAPMUX_REG_OUT_EN
    chk("midrst_rom_ce_n", 32'(bus.rom_ce_n), 32'd1);
`endif
    tick(1); rst_n = 1'b1;
    tick(4); pin_lock("relock_pre", 1'b0, 3'd0, 1'b0);
    tick(1); pin_lock("relock", 1'b1, 3'd3, 1'b0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
